// File: rtl/f0_pc_gen.sv
// Fetch stage 0: holds the fetch PC and picks the next fetch address.
// Each fetch address is turned into the even/odd cache-line pair that covers
// the fetch window, because the window may straddle a line boundary.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_BUBBLE  | one dead cycle after reset or redirect, nothing presented
// ST_RUN     | fetch block presented; accepted on any cycle without stall
// ST_HALT    | PC has bit 0 set; fetch stops until a redirect arrives
module f0_pc_gen #(
    parameter int                XLEN        = 32,
    parameter int                CLC_WIDTH   = 26,
    parameter int                FETCH_BYTES = 16,
    parameter logic [XLEN-1:0]   RESET_PC    = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 redirect_valid_i,
    input  logic [XLEN-1:0]      redirect_pc_i,
    input  logic                 bp_valid_i,
    input  logic [XLEN-1:0]      bp_target_i,
    input  logic                 stall_i,
    output logic                 fetch_valid_o,
    output logic [XLEN-1:0]      pc_out_o,
    output logic [CLC_WIDTH-1:0] clc_even_o,
    output logic [CLC_WIDTH-1:0] clc_odd_o,
    output logic                 misalign_o,
    output logic [1:0]           epoch_o
);

    typedef enum logic [1:0] {
        ST_BUBBLE = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALT   = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] FETCH_INC  = XLEN'(FETCH_BYTES);
    localparam logic [XLEN-1:0] FETCH_MASK = ~(FETCH_INC - XLEN'(1));

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic            pend_valid_q, pend_valid_d;
    logic            misalign_q, misalign_d;
    logic [1:0]      epoch_q, epoch_d;

    logic [XLEN-1:0]      seq_pc;
    logic [XLEN-1:0]      target_pc;
    logic [CLC_WIDTH-1:0] line_cur;
    logic [CLC_WIDTH-1:0] line_nxt;

    assign seq_pc   = (pc_q & FETCH_MASK) + FETCH_INC;
    assign line_cur = pc_q[XLEN-1 -: CLC_WIDTH];
    assign line_nxt = line_cur + CLC_WIDTH'(1);

    // Target for an accepted block: a fresh prediction beats one remembered
    // from a stalled cycle, which beats the sequential increment.
    always_comb begin
        target_pc = seq_pc;
        if (bp_valid_i) begin
            target_pc = bp_target_i;
        end else if (pend_valid_q) begin
            target_pc = pend_pc_q;
        end
    end

    // Next-state and next-PC selection; redirect overrides everything.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_pc_d    = pend_pc_q;
        pend_valid_d = pend_valid_q;
        misalign_d   = misalign_q;
        epoch_d      = epoch_q;
        if (redirect_valid_i) begin
            pc_d         = redirect_pc_i;
            epoch_d      = epoch_q + 2'd1;
            pend_valid_d = 1'b0;
            misalign_d   = 1'b0;
            state_d      = ST_BUBBLE;
        end else begin
            unique case (state_q)
                ST_BUBBLE: begin
                    if (pc_q[0]) begin
                        state_d    = ST_HALT;
                        misalign_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stall_i) begin
                        if (bp_valid_i) begin
                            pend_valid_d = 1'b1;
                            pend_pc_d    = bp_target_i;
                        end
                    end else begin
                        pc_d         = target_pc;
                        pend_valid_d = 1'b0;
                        if (target_pc[0]) begin
                            state_d    = ST_HALT;
                            misalign_d = 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    state_d = ST_HALT;
                end
                default: begin
                    state_d = ST_BUBBLE;
                end
            endcase
        end
    end

    // State and PC registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_BUBBLE;
            pc_q         <= RESET_PC;
            pend_pc_q    <= '0;
            pend_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
            epoch_q      <= 2'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_pc_q    <= pend_pc_d;
            pend_valid_q <= pend_valid_d;
            misalign_q   <= misalign_d;
            epoch_q      <= epoch_d;
        end
    end

    // Line pair: the even-indexed line always goes to clc_even, whichever of
    // the two the window starts in.
    always_comb begin
        if (line_cur[0]) begin
            clc_odd_o  = line_cur;
            clc_even_o = line_nxt;
        end else begin
            clc_even_o = line_cur;
            clc_odd_o  = line_nxt;
        end
    end

    assign fetch_valid_o = (state_q == ST_RUN);
    assign pc_out_o      = pc_q;
    assign misalign_o    = misalign_q;
    assign epoch_o       = epoch_q;

endmodule
